// File: rtl/regfile_wr_arbiter.sv
// Fixed-priority arbiter for the single regfile write port. Grant is combinational, the write follows one cycle later, and hold stalls grants only.
// Optional aging promotion against starvation: define RF_ARB_STARVE_EN.
module regfile_wr_arbiter #(
  parameter int NREQ         = 3,
  parameter int DW           = 32,
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               hold,
  output logic [NREQ-1:0]    gnt,
  output logic               ctrl_writeEnable,
  output logic [AW-1:0]      ctrl_writeReg,
  output logic [DW-1:0]      data_writeReg,
  output logic               busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || STARVE_LIMIT < 1) begin : g_param_out_of_range
  end

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] gnt_c;
  logic [IW-1:0]   sel;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

`ifdef RF_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]   age [NREQ];
  logic [NREQ-1:0] promoted;

  always_comb begin
    promoted = '0;
    for (int i = 0; i < NREQ; i++)
      promoted[i] = req[i] && (age[i] == CW'(STARVE_LIMIT));
  end

  // Any promoted requester masks out every non-promoted one.
  assign cand = (|promoted) ? promoted : req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || gnt_c[i])
          age[i] <= '0;
        else if (!hold && (age[i] != CW'(STARVE_LIMIT)))
          age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  assign cand = req;
`endif

  // Scan downward so the lowest candidate index is the last (winning) assignment.
  always_comb begin
    gnt_c = '0;
    sel   = '0;
    if (reset && !hold) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (cand[i]) begin
          gnt_c    = '0;
          gnt_c[i] = 1'b1;
          sel      = IW'(i);
        end
      end
    end
  end

  assign win_addr = req_addr[sel*AW +: AW];
  assign win_data = req_data[sel*DW +: DW];

  assign gnt  = gnt_c;
  assign busy = reset && (|(req & ~gnt_c));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else if (|gnt_c) begin
      ctrl_writeEnable <= (win_addr != '0);
      ctrl_writeReg    <= win_addr;
      data_writeReg    <= win_data;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed and random checks of regfile_wr_arbiter against a behavioural model.
module tb_regfile_wr_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int LIM  = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               hold;
  logic [NREQ-1:0]    gnt;
  logic               ctrl_writeEnable;
  logic [AW-1:0]      ctrl_writeReg;
  logic [DW-1:0]      data_writeReg;
  logic               busy;

  regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .hold(hold), .gnt(gnt), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] d [NREQ];

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference state: the expected write-port contents and per-requester wait ages.
  logic          m_we;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_wd;
  int            m_age [NREQ];
  logic [NREQ-1:0] last_gnt;

  function automatic logic [NREQ-1:0] lowest(input logic [NREQ-1:0] v);
    return v & (~v + 1'b1);
  endfunction

  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] c;
    if (!reset || hold) return '0;
    c = req;
`ifdef RF_ARB_STARVE_EN
    begin
      logic [NREQ-1:0] p;
      p = '0;
      for (int i = 0; i < NREQ; i++) if (req[i] && m_age[i] >= LIM) p[i] = 1'b1;
      if (p != 0) c = p;
    end
`endif
    return lowest(c);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
  task automatic step();
    logic [NREQ-1:0] eg;
    int k;
    #3;
    eg = model_gnt();
    chk("gnt", 64'(gnt), 64'(eg));
    chk("busy", 64'(busy), 64'(|(req & ~eg)));
    @(posedge clock);
    #1;
    if (eg != 0) begin
      k = $clog2(eg);
      m_we = (a[k] != 0);
      m_wr = a[k];
      m_wd = d[k];
    end else begin
      m_we = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!req[i] || eg[i]) m_age[i] = 0;
      else if (!hold && m_age[i] < LIM) m_age[i]++;
    end
    last_gnt = eg;
    chk("we", 64'(ctrl_writeEnable), 64'(m_we));
    chk("wreg", 64'(ctrl_writeReg), 64'(m_wr));
    chk("wdata", 64'(data_writeReg), 64'(m_wd));
  endtask

  task automatic assert_reset(input string tag);
    reset = 1'b0;
    #1;
    m_we = 1'b0; m_wr = '0; m_wd = '0;
    for (int i = 0; i < NREQ; i++) m_age[i] = 0;
    chk({tag, "_we"}, 64'(ctrl_writeEnable), 64'd0);
    chk({tag, "_wreg"}, 64'(ctrl_writeReg), 64'd0);
    chk({tag, "_wdata"}, 64'(data_writeReg), 64'd0);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int first2;
    reset = 1'b0; hold = 1'b0; req = '0;
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; d[i] = '0; end
    last_gnt = '0;
    assert_reset("por");
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;

    // Reset mid-write with all requesting, then first grant goes to requester 0.
    req = 3'b111; a[0] = 5'd3; a[1] = 5'd4; a[2] = 5'd5;
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
    step();
    assert_reset("midrst");
    #2 reset = 1'b1;
    step();
    chk("post_rst_first_gnt", 64'(last_gnt), 64'b001);
    req = '0;
    step();

    // Single write from requester 1.
    req = 3'b010; a[1] = 5'd7; d[1] = 32'hDEADBEEF;
    step();
    chk("single_gnt", 64'(last_gnt), 64'b010);
    chk("single_we", 64'(ctrl_writeEnable), 64'd1);
    chk("single_reg", 64'(ctrl_writeReg), 64'd7);
    chk("single_data", 64'(data_writeReg), 64'hDEADBEEF);
    req = '0;

    // Contention: each requester drops after its grant.
    req = 3'b111; a[0] = 5'd10; a[1] = 5'd11; a[2] = 5'd12;
    d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("contend_order", 64'(last_gnt), 64'(3'b001 << n));
      req = req & ~last_gnt;
    end
    step();

    // Register 0 write is granted but produces no enable.
    req = 3'b001; a[0] = 5'd0; d[0] = 32'h1234;
    step();
    chk("zero_gnt", 64'(last_gnt), 64'b001);
    chk("zero_we", 64'(ctrl_writeEnable), 64'd0);
    req = '0;

    // Grant in N, hold in N+1: the write still lands; held request waits.
    req = 3'b010; a[1] = 5'd3; d[1] = 32'h55;
    step();
    req = 3'b001; a[0] = 5'd9; d[0] = 32'h99; hold = 1'b1;
    for (int n = 0; n < 3; n++) step();
    hold = 1'b0;
    step();
    chk("hold_release_gnt", 64'(last_gnt), 64'b001);
    req = '0;
    step();

    // Requester 0 re-requests every cycle while requester 2 waits.
    req = 3'b101; a[2] = 5'd17; d[2] = 32'h2222;
    first2 = -1;
    for (int n = 1; n <= 8; n++) begin
      a[0] = 5'($urandom_range(1, 31)); d[0] = $urandom;
      step();
      if (last_gnt[2] && first2 < 0) first2 = n;
      if (last_gnt[2]) req[2] = 1'b0;
    end
`ifdef RF_ARB_STARVE_EN
    chk("starve_cycle", 64'(first2), 64'd5);
`else
    chk("starve_cycle", 64'(first2), 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    req = '0;
    step();

    // Random traffic obeying the hold-until-granted handshake.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_gnt[i]) begin
          req[i] = ($urandom_range(0, 1) == 1);
          a[i] = 5'($urandom); d[i] = $urandom;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          a[i] = 5'($urandom); d[i] = $urandom;
        end
      end
      hold = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port between NREQ requesters: pipeline writeback (req 0), multdiv completion (req 1), and exception/status writer (req 2).
- Grants at most one requester per cycle under fixed priority, lowest index highest.
- Registers the winning address/data into a one-stage output pipe that drives the regfile write controls.
- Register 0 writes are granted but suppressed at the port.

Parameters:
- NREQ, 3, number of requesters (2..8)
- DW, 32, write data width
- AW, 5, register address width
- STARVE_LIMIT, 4, consecutive losing cycles before aging promotion (used only with optional feature)

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req  input  NREQ  per-requester write request; held with addr/data until granted
- req_addr  input  NREQ*AW  packed destination registers; requester i at [i*AW +: AW]
- req_data  input  NREQ*DW  packed write data; requester i at [i*DW +: DW]
- hold  input  1  when 1, no grants issued (regfile/pipeline freeze)
- gnt  output  NREQ  one-hot grant, combinational in the same cycle as selection
- ctrl_writeEnable  output  1  regfile write enable
- ctrl_writeReg  output  AW  regfile write address
- data_writeReg  output  DW  regfile write data
- busy  output  1  1 when any req bit is set and not granted this cycle

Behaviour:
- Reset asserted: ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, gnt=0, busy=0, internal age counters=0. Takes effect immediately and asynchronously. An in-flight registered write is discarded, not completed.
- Selection (combinational): if hold=0 and req!=0, gnt = lowest set bit of req. Otherwise gnt=0.
- Latency: a grant in cycle N produces the write at the output in cycle N+1.
  - ctrl_writeEnable=1 only if the granted addr != 0.
  - ctrl_writeReg/data_writeReg carry the granted values.
  - With no grant, ctrl_writeEnable=0 and addr/data hold their last values.
- Handshake: a requester treats gnt[i]=1 at a rising edge as consumption. It may keep req[i]=1 with new addr/data for back-to-back writes. It must not change addr/data while req[i]=1 and ungranted.
- Each cycle produces at most one write. Back-to-back grants to the same or different requesters give one write per cycle with no bubble.
- hold=1 blocks grants only. A write already in the output stage still appears next cycle. When hold deasserts, arbitration resumes the same cycle.
- busy = |(req & ~gnt). It is combinational and asserted during hold whenever req!=0.
- A request with addr=0 is granted normally (the requester is freed), but produces no write enable.
- Two requesters targeting the same register in consecutive cycles: both writes issue in grant order; no merging.
- Out-of-range requester bits (NREQ<8) do not exist; no X propagation on gnt for req=0.

Optional Feature:
- Macro: RF_ARB_STARVE_EN.
- Defined: each requester has a saturating age counter of width clog2(STARVE_LIMIT+1).
  - The counter increments on each cycle with req[i]=1, gnt[i]=0 and hold=0.
  - It clears on grant, on req[i]=0, and on reset.
  - A requester whose age reaches STARVE_LIMIT is promoted above all non-promoted requesters. Among promoted requesters, the lowest index wins.
  - Counters do not advance while hold=1.
- Undefined: no counters; pure fixed priority. Requester NREQ-1 can starve indefinitely under continuous higher-priority traffic.

Test Plan:
- Reset: reset=0 mid-write with req=3'b111 -> all outputs 0 immediately; after release, first grant is gnt=3'b001.
- Single write: req=3'b010, addr1=7, data1=32'hDEADBEEF in cycle N -> gnt=3'b010 in cycle N. In N+1: ctrl_writeEnable=1, ctrl_writeReg=7, data_writeReg=32'hDEADBEEF.
- Contention: req=3'b111 held, requesters drop req after grant -> grants 001, 010, 100 on consecutive cycles. Three writes appear on N+1..N+3; busy=1 for the first two cycles, then 0.
- Zero register: req0 with addr=0, data=32'h1234 -> gnt=3'b001, ctrl_writeEnable=0 next cycle.
- Hold: req=3'b001 with hold=1 for 3 cycles -> gnt=0 and busy=1 throughout. Grant is issued in the cycle hold drops; the write follows one cycle later.
- Starvation (RF_ARB_STARVE_EN, STARVE_LIMIT=4): req0 continuously re-requesting, req2 held -> req2 granted on its 5th requesting cycle. Without the macro, req2 is never granted.
